// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [4*DIGITS-1:0] scratch_q, scratch_d, adj, bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d, done_q, done_d;
  // every digit is corrected from its pre-shift value, all in parallel
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = scratch_q[4*i+:4] >= 4'd5 ? scratch_q[4*i+:4] + 4'd3 : scratch_q[4*i+:4];
  end
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    case (state_q)
      IDLE: if (start) begin
        state_d   = SHIFT;
        shift_d   = bin;
        scratch_d = '0;
        cnt_d     = CW'(WIDTH);
      end
      SHIFT: begin
        {scratch_d, shift_d} = {adj[4*DIGITS-2:0], shift_q, 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          bcd_d   = {adj[4*DIGITS-2:0], shift_q[WIDTH-1]};
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d == SHIFT;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench; stimulus pushes expected BCD, a negedge monitor pops on done
module tb_bin2bcd_seq;
  logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [15:0] bin = '0;
  logic        busy, done;
  logic [19:0] bcd;
  int checks = 0, errors = 0, done_cnt = 0, cyc = 0;
  logic [19:0] exp_q[$];
  logic [19:0] prev_bcd = '0;
  logic        prev_rst = 1'b1;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clock(clock), .reset(reset), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit digits_ok(input logic [19:0] b);
    for (int i = 0; i < 5; i++) if (b[4*i+:4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // monitor: scoreboard pop on done, plus exclusivity and output-stability watch
  always @(negedge clock) begin
    if (busy && done) begin
      errors++;
      $display("FAIL busy_done_excl: got busy=1 done=1 want not both");
    end
    if (bcd !== prev_bcd && !done && !prev_rst) begin
      errors++;
      $display("FAIL bcd_stable: got %0h want %0h", bcd, prev_bcd);
    end
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got bcd %0h want no done", bcd);
      end else begin
        chk("bcd", 32'(bcd), 32'(exp_q.pop_front()));
        chk("digits_le9", 32'(digits_ok(bcd)), 32'd1);
      end
    end
    prev_bcd = bcd;
    prev_rst = reset;
  end

  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      @(posedge clock); #1;
      n++;
    end
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles want done", n);
    end
  endtask

  task automatic conv(input logic [15:0] b, input logic [19:0] e, input bit timing);
    int n, nb;
    start = 1'b1;
    bin = b;
    exp_q.push_back(e);
    @(posedge clock); #1;
    start = 1'b0;
    bin = ~b;
    wait_done(n, nb);
    if (timing) begin
      chk("latency", 32'(n), 32'd16);
      chk("busy_cycles", 32'(nb), 32'd16);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    int n, nb, d0, tp, t;
    logic [15:0] cnt;
    logic [15:0] vals [3];
    vals = '{16'd1111, 16'd2222, 16'd3333};
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    conv(16'd0, 20'h00000, 1'b1);
    conv(16'd65535, 20'h65535, 1'b1);
    conv(16'd1234, 20'h01234, 1'b1);
    conv(16'd9999, 20'h09999, 1'b1);
    conv(16'd10, 20'h00010, 1'b1);
    // a start raised mid-conversion must be dropped, not queued
    d0 = done_cnt;
    start = 1'b1;
    bin = 16'd500;
    exp_q.push_back(20'h00500);
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    start = 1'b1;
    bin = 16'd42;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(n, nb);
    repeat (25) begin @(posedge clock); #1; end
    chk("one_done_pulse", 32'(done_cnt - d0), 32'd1);
    // reset mid-conversion discards the partial result
    conv(16'd777, 20'h00777, 1'b0);
    start = 1'b1;
    bin = 16'd300;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_bcd", 32'(bcd), 32'd0);
    d0 = done_cnt;
    repeat (25) begin @(posedge clock); #1; end
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    conv(16'd88, 20'h00088, 1'b1);
    // start held high: one conversion every 18 cycles
    tp = 0;
    start = 1'b1;
    bin = vals[0];
    exp_q.push_back(ref_bcd(int'(vals[0])));
    for (int i = 0; i < 3; i++) begin
      wait_done(n, nb);
      t = cyc;
      if (i > 0) chk("b2b_period", 32'(t - tp), 32'd18);
      tp = t;
      if (i == 2) start = 1'b0;
      @(posedge clock); #1;
      if (i < 2) begin
        bin = vals[i+1];
        exp_q.push_back(ref_bcd(int'(vals[i+1])));
      end
    end
    repeat (3) begin @(posedge clock); #1; end
    // counter-driven sweep against a decimal reference
    cnt = 16'($urandom);
    for (int i = 0; i < 2000; i++) begin
      cnt = cnt + 16'($urandom_range(1, 37));
      conv(cnt, ref_bcd(int'(cnt)), 1'b0);
    end
    repeat (5) begin @(posedge clock); #1; end
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
